// File: rtl/bitwise_seq_pkg.sv
// Shared definitions for the bitwise command sequencer: opcodes, FSM states,
// pad bit positions and the MIX helper used by the datapath.
package bitwise_seq_pkg;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_MIX  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_t;

  // uio_in fields
  localparam int UIO_VALID = 7;
  localparam int UIO_OP_HI = 6;
  localparam int UIO_OP_LO = 4;

  // uio_out fields
  localparam int UIO_READY = 0;
  localparam int UIO_BUSY  = 1;
  localparam int UIO_DONE  = 2;
  localparam int UIO_ERR   = 3;

  localparam logic [7:0] UIO_OE_MASK = 8'h0F;

  // MIX: OR on the low seven bits, XOR on the top bit
  function automatic logic [7:0] mix_bits(input logic [7:0] a, input logic [7:0] b);
    return {a[7] ^ b[7], a[6:0] | b[6:0]};
  endfunction

endpackage

// File: rtl/bitwise_seq_if.sv
// Pad bundle of the tile: command inputs and status/accumulator outputs.
interface bitwise_seq_if;

  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

endinterface

// File: rtl/bitwise_alu.sv
// Shared 8-bit bitwise datapath: applies one opcode to the accumulator and
// flags the reserved opcode as illegal.
module bitwise_alu
  import bitwise_seq_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] acc,
  input  logic [7:0] d,
  output logic [7:0] res,
  output logic       illegal
);

  // Opcode decode; unknown/reserved codes leave the accumulator untouched
  always_comb begin
    res     = acc;
    illegal = 1'b0;
    case (op)
      OP_LOAD: res = d;
      OP_OR:   res = acc | d;
      OP_AND:  res = acc & d;
      OP_XOR:  res = acc ^ d;
      OP_MIX:  res = mix_bits(acc, d);
      OP_NOT:  res = ~acc;
      OP_CLR:  res = 8'h00;
      OP_RSVD: begin
        res     = acc;
        illegal = 1'b1;
      end
      default: begin
        res     = acc;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/tt_um_bitwise_sequencer.sv
// Command-queued sequencer: commands land in a small FIFO and are applied in
// order to an 8-bit accumulator, each one holding the datapath EXEC_CYCLES cycles.
module tt_um_bitwise_sequencer
  import bitwise_seq_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int EXEC_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  bitwise_seq_if.slave  pads
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] RELOAD   = TMR_W'(EXEC_CYCLES - 1);

  logic [10:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;
  logic [TMR_W-1:0] cnt;
  logic [7:0]       acc;
  logic             err;
  logic             done;

  logic             cmd_valid_s;
  logic             ready_s;
  logic             busy_s;
  logic             push_s;
  logic             commit_s;
  logic [10:0]      head_s;
  logic [7:0]       alu_res_s;
  logic             alu_illegal_s;
  logic [7:0]       uio_out_s;
  logic             unused_bits;

  // Handshake and commit qualifiers, all derived from registered state
  always_comb begin
    cmd_valid_s = pads.uio_in[UIO_VALID];
    ready_s     = (count != FULL_CNT);
    busy_s      = (state == ST_EXEC) | (count != {CNT_W{1'b0}});
    push_s      = ena & cmd_valid_s & ready_s;
    commit_s    = ena & (state == ST_EXEC) & (cnt == {TMR_W{1'b0}});
    head_s      = mem[rd_ptr];
  end

  assign unused_bits = &{1'b0, pads.uio_in[3:0]};

  bitwise_alu u_alu (
    .op      (head_s[10:8]),
    .acc     (acc),
    .d       (head_s[7:0]),
    .res     (alu_res_s),
    .illegal (alu_illegal_s)
  );

  // Command FIFO: storage, pointers and occupancy; a same-edge pop does not
  // make room for that edge's push because ready looks at the old count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 11'h000;
      end
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else if (ena) begin
      if (push_s) begin
        mem[wr_ptr] <= {pads.uio_in[UIO_OP_HI:UIO_OP_LO], pads.ui_in};
        wr_ptr      <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (commit_s) begin
        rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      count <= count + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, commit_s};
    end
  end

  // Sequencer FSM with execution timer, accumulator, sticky error and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= {TMR_W{1'b0}};
      acc   <= 8'h00;
      err   <= 1'b0;
      done  <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (count != {CNT_W{1'b0}}) begin
            state <= ST_EXEC;
            cnt   <= RELOAD;
          end
        end
        ST_EXEC: begin
          if (cnt != {TMR_W{1'b0}}) begin
            cnt <= cnt - {{(TMR_W-1){1'b0}}, 1'b1};
          end else begin
            acc <= alu_res_s;
            if (head_s[10:8] == OP_CLR) begin
              err <= 1'b0;
            end else if (alu_illegal_s) begin
              err <= 1'b1;
            end
            // Decide on what is left after this pop; a push landing now
            // restarts from IDLE instead of chaining
            if (count > {{(CNT_W-1){1'b0}}, 1'b1}) begin
              cnt <= RELOAD;
            end else begin
              state <= ST_IDLE;
              done  <= ~push_s;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= {TMR_W{1'b0}};
        end
      endcase
    end
  end

  // Status byte assembly
  always_comb begin
    uio_out_s            = 8'h00;
    uio_out_s[UIO_READY] = ready_s;
    uio_out_s[UIO_BUSY]  = busy_s;
    uio_out_s[UIO_DONE]  = done;
    uio_out_s[UIO_ERR]   = err;
  end

  assign pads.uo_out  = acc;
  assign pads.uio_out = uio_out_s;
  assign pads.uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_tt_um_bitwise_sequencer.sv
// Self-checking bench for the bitwise command sequencer (DEPTH=4, EXEC_CYCLES=4).
module tb_tt_um_bitwise_sequencer;
  import bitwise_seq_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;

  bitwise_seq_if pads ();

  tt_um_bitwise_sequencer #(.DEPTH(4), .EXEC_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .pads  (pads)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] d;
    logic [7:0] acc;
    logic       err;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         edge_n = 0;
  logic [7:0] mdl_acc = 8'h00;
  logic       mdl_err = 1'b0;
  logic [8:0] exp_q [$];
  vec_t       tbl [12];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] d, input logic e);
    case (op)
      3'd0:    return {e, d};
      3'd1:    return {e, a | d};
      3'd2:    return {e, a & d};
      3'd3:    return {e, a ^ d};
      3'd4:    return {e, a[7] ^ d[7], a[6:0] | d[6:0]};
      3'd5:    return {e, ~a};
      3'd6:    return {1'b0, 8'h00};
      default: return {1'b1, a};
    endcase
  endfunction

  task automatic model_push(input logic [2:0] op, input logic [7:0] d);
    {mdl_err, mdl_acc} = model(op, mdl_acc, d, mdl_err);
    exp_q.push_back({mdl_err, mdl_acc});
  endtask

  task automatic pop_check(input string name);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      check_int({name, "_qempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check8({name, "_acc"}, pads.uo_out, e[7:0]);
      check8({name, "_err"}, 8'(pads.uio_out[UIO_ERR]), 8'(e[8]));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic set_cmd(input logic v, input logic [2:0] op, input logic [7:0] d);
    pads.uio_in = {v, op, 4'b0000};
    pads.ui_in  = d;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    ena   = 1'b1;
    set_cmd(1'b0, 3'd0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check8("rst_uo_out", pads.uo_out, 8'h00);
    check8("rst_uio_out", pads.uio_out, 8'h01);
    check8("rst_uio_oe", pads.uio_oe, 8'h0F);
    rst_n   = 1'b1;
    edge_n  = 0;
    mdl_acc = 8'h00;
    mdl_err = 1'b0;
    exp_q.delete();
  endtask

  // One command from IDLE: push, wait for done, compare against the queue head
  task automatic run_single(input logic [2:0] op, input logic [7:0] d, input string tag);
    int  waited;
    bit  seen;
    check8({tag, "_ready"}, 8'(pads.uio_out[UIO_READY]), 8'h01);
    set_cmd(1'b1, op, d);
    tick;
    set_cmd(1'b0, 3'd0, 8'h00);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 20) begin
      tick;
      waited++;
      if (pads.uio_out[UIO_DONE]) seen = 1'b1;
    end
    check_int({tag, "_latency"}, waited, 5);
    pop_check(tag);
    tick;
    check8({tag, "_done_clr"}, 8'(pads.uio_out[UIO_DONE]), 8'h00);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    int acc_edge [5];
    logic [2:0] ops4 [5];
    logic [7:0] ds4  [5];

    set_cmd(1'b0, 3'd0, 8'h00);

    // ---- 1. reset values, async assertion mid-cycle
    do_reset;
    model_push(OP_LOAD, 8'h5A);
    run_single(OP_LOAD, 8'h5A, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    check8("async_uo_out", pads.uo_out, 8'h00);
    check8("async_uio_out", pads.uio_out, 8'h01);

    // ---- table-driven single commands (accumulator carries between rows)
    tbl[0]  = '{OP_LOAD, 8'h3C, 8'h3C, 1'b0};
    tbl[1]  = '{OP_OR,   8'hC0, 8'hFC, 1'b0};
    tbl[2]  = '{OP_AND,  8'h0F, 8'h0C, 1'b0};
    tbl[3]  = '{OP_XOR,  8'hFF, 8'hF3, 1'b0};
    tbl[4]  = '{OP_MIX,  8'h8C, 8'h7F, 1'b0};
    tbl[5]  = '{OP_NOT,  8'h00, 8'h80, 1'b0};
    tbl[6]  = '{OP_RSVD, 8'h55, 8'h80, 1'b1};
    tbl[7]  = '{OP_OR,   8'h01, 8'h81, 1'b1};
    tbl[8]  = '{OP_CLR,  8'hA5, 8'h00, 1'b0};
    tbl[9]  = '{OP_MIX,  8'h80, 8'h80, 1'b0};
    tbl[10] = '{OP_MIX,  8'h80, 8'h00, 1'b0};
    tbl[11] = '{OP_LOAD, 8'hFF, 8'hFF, 1'b0};
    do_reset;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({tbl[i].err, tbl[i].acc});
      run_single(tbl[i].op, tbl[i].d, $sformatf("tbl%0d", i));
    end

    // ---- 2. back-to-back LOAD 0x0F, OR 0xF0
    do_reset;
    done_cnt = 0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 1) begin
        model_push(OP_LOAD, 8'h0F);
        set_cmd(1'b1, OP_LOAD, 8'h0F);
      end else if (e == 2) begin
        model_push(OP_OR, 8'hF0);
        set_cmd(1'b1, OP_OR, 8'hF0);
      end else begin
        set_cmd(1'b0, 3'd0, 8'h00);
      end
      tick;
      if (e == 6 || e == 10) pop_check($sformatf("b2b_e%0d", e));
      check8($sformatf("b2b_uo_e%0d", e), pads.uo_out,
             (e < 6) ? 8'h00 : ((e < 10) ? 8'h0F : 8'hFF));
      check8($sformatf("b2b_busy_e%0d", e), 8'(pads.uio_out[UIO_BUSY]),
             (e < 10) ? 8'h01 : 8'h00);
      if (pads.uio_out[UIO_DONE]) done_cnt++;
      if (e == 10) check8("b2b_done_e10", 8'(pads.uio_out[UIO_DONE]), 8'h01);
    end
    check_int("b2b_done_count", done_cnt, 1);

    // ---- 3. LOAD/MIX/XOR/NOT chain
    do_reset;
    model_push(OP_LOAD, 8'h80); run_single(OP_LOAD, 8'h80, "t3_load");
    model_push(OP_MIX, 8'h81);  run_single(OP_MIX, 8'h81, "t3_mix");
    check8("t3_mix_const", pads.uo_out, 8'h01);
    model_push(OP_XOR, 8'hFF);  run_single(OP_XOR, 8'hFF, "t3_xor");
    check8("t3_xor_const", pads.uo_out, 8'hFE);
    model_push(OP_NOT, 8'h00);  run_single(OP_NOT, 8'h00, "t3_not");
    check8("t3_not_const", pads.uo_out, 8'h01);

    // ---- 4. five pushes into a four-deep FIFO
    ops4 = '{OP_LOAD, OP_XOR, OP_OR, OP_AND, OP_NOT};
    ds4  = '{8'h11, 8'h22, 8'h44, 8'h0F, 8'h00};
    do_reset;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          bit ok;
          ok = 1'b0;
          set_cmd(1'b1, ops4[i], ds4[i]);
          for (int w = 0; w < 20 && !ok; w++) begin
            if (pads.uio_out[UIO_READY]) ok = 1'b1;
            tick;
          end
          acc_edge[i] = ok ? edge_n : -1;
          if (ok) model_push(ops4[i], ds4[i]);
        end
        set_cmd(1'b0, 3'd0, 8'h00);
      end
      begin
        for (int e = 1; e <= 24; e++) begin
          @(posedge clk);
          #1;
          if (e == 4 || e == 5) check8($sformatf("full_ready_e%0d", e), 8'(pads.uio_out[UIO_READY]), 8'h00);
          if (e == 6) check8("full_ready_e6", 8'(pads.uio_out[UIO_READY]), 8'h01);
          if (e == 6 || e == 10 || e == 14 || e == 18 || e == 22) pop_check($sformatf("full_e%0d", e));
          if (e == 18) check8("full_done_e18", 8'(pads.uio_out[UIO_DONE]), 8'h00);
          if (e == 22) check8("full_done_e22", 8'(pads.uio_out[UIO_DONE]), 8'h01);
          if (e == 23) check8("full_done_e23", 8'(pads.uio_out[UIO_DONE]), 8'h00);
        end
      end
    join
    check_int("full_accept0", acc_edge[0], 1);
    check_int("full_accept3", acc_edge[3], 4);
    check_int("full_accept4", acc_edge[4], 7);
    check8("full_final", pads.uo_out, 8'hF8);

    // ---- 5. reserved opcode, sticky error, CLR
    do_reset;
    model_push(OP_LOAD, 8'h3C);  run_single(OP_LOAD, 8'h3C, "t5_load");
    model_push(OP_RSVD, 8'hAA);  run_single(OP_RSVD, 8'hAA, "t5_rsvd");
    check8("t5_err_set", 8'(pads.uio_out[UIO_ERR]), 8'h01);
    model_push(OP_AND, 8'hF0);   run_single(OP_AND, 8'hF0, "t5_sticky");
    check8("t5_err_sticky", 8'(pads.uio_out[UIO_ERR]), 8'h01);
    model_push(OP_CLR, 8'h00);   run_single(OP_CLR, 8'h00, "t5_clr");
    check8("t5_err_clr", 8'(pads.uio_out[UIO_ERR]), 8'h00);

    // ---- 6. freeze with ena=0 mid-EXEC, then reset mid-EXEC
    do_reset;
    model_push(OP_LOAD, 8'h12); set_cmd(1'b1, OP_LOAD, 8'h12); tick;
    model_push(OP_OR, 8'h34);   set_cmd(1'b1, OP_OR, 8'h34);   tick;
    model_push(OP_XOR, 8'hFF);  set_cmd(1'b1, OP_XOR, 8'hFF);  tick;
    set_cmd(1'b0, 3'd0, 8'h00);
    ena = 1'b0;
    for (int e = 4; e <= 8; e++) begin
      tick;
      check8($sformatf("frz_uo_e%0d", e), pads.uo_out, 8'h00);
      check8($sformatf("frz_uio_e%0d", e), pads.uio_out, 8'h03);
    end
    ena = 1'b1;
    tick;
    tick;
    check8("frz_uo_e10", pads.uo_out, 8'h00);
    tick;
    pop_check("frz_commit_e11");
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    check8("t6_rst_uo", pads.uo_out, 8'h00);
    check8("t6_rst_uio", pads.uio_out, 8'h01);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick;
      check8($sformatf("t6_post_uo_e%0d", e), pads.uo_out, 8'h00);
      check8($sformatf("t6_post_uio_e%0d", e), pads.uio_out, 8'h01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
